// File: rtl/if_id_stage.sv
// IF/ID pipeline register for the 5-stage MIPS core. It absorbs instruction-memory
// wait states with a one-entry hold buffer and applies exception and eret flushes.
module if_id_stage #(
    parameter logic [31:0] PC_START   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] F_PC,
    input  logic [31:0] F_Instr,
    input  logic        F_ExcAdEL,
    input  logic        i_ready,
    input  logic        D_isBranch,
    input  logic        En,
    input  logic        req,
    input  logic        flush,
    output logic        if_stall,
    output logic [31:0] D_PC,
    output logic [31:0] D_Instr,
    output logic [4:0]  D_ExcCode,
    output logic        D_BD,
    output logic        D_Valid,
    output logic        dbg_held
);

    // Handshake: the fetch side offers a word that is valid when i_ready=1 (or when
    // it faults), and decode accepts it on a rising edge with En=1. A valid word
    // offered while En=0 is parked in the hold buffer instead of being dropped.
    typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} hold_state_t;

    hold_state_t state, state_next;

    logic [31:0] buf_pc;
    logic [31:0] buf_instr;
    logic        buf_adel;
    logic        buf_bd;
    logic        buf_load;

    logic [31:0] src_pc;
    logic [31:0] src_instr;
    logic        src_adel;
    logic        src_bd;
    logic        src_valid;

    always_comb begin
        if (state == HELD) begin
            src_pc    = buf_pc;
            src_instr = buf_instr;
            src_adel  = buf_adel;
            src_bd    = buf_bd;
            src_valid = 1'b1;
        end else begin
            src_pc    = F_PC;
            src_instr = F_Instr;
            src_adel  = F_ExcAdEL;
            src_bd    = D_isBranch;
            src_valid = i_ready | F_ExcAdEL;
        end
    end

    // A faulting fetch is forwarded immediately and never waits on memory.
    assign if_stall = (state == EMPTY) & ~i_ready & ~F_ExcAdEL;
    assign dbg_held = (state == HELD);

    always_comb begin
        state_next = state;
        buf_load   = 1'b0;
        if (req || flush) begin
            state_next = EMPTY;
        end else if (!En) begin
            if (state == EMPTY && src_valid) begin
                state_next = HELD;
                buf_load   = 1'b1;
            end
        end else if (src_valid) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            buf_pc    <= PC_START;
            buf_instr <= 32'd0;
            buf_adel  <= 1'b0;
            buf_bd    <= 1'b0;
        end else begin
            state <= state_next;
            if (buf_load) begin
                buf_pc    <= F_PC;
                buf_instr <= F_Instr;
                buf_adel  <= F_ExcAdEL;
                buf_bd    <= D_isBranch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            D_PC      <= PC_START;
            D_Instr   <= 32'd0;
            D_ExcCode <= 5'd0;
            D_BD      <= 1'b0;
            D_Valid   <= 1'b0;
        end else if (req) begin
            D_PC      <= HANDLER_PC;
            D_Instr   <= 32'd0;
            D_ExcCode <= 5'd0;
            D_BD      <= 1'b0;
            D_Valid   <= 1'b0;
        end else if (flush) begin
            D_PC      <= F_PC;
            D_Instr   <= 32'd0;
            D_ExcCode <= 5'd0;
            D_BD      <= 1'b0;
            D_Valid   <= 1'b0;
        end else if (En) begin
            if (src_valid) begin
                D_PC      <= src_pc;
                D_BD      <= src_bd;
                D_Valid   <= 1'b1;
                D_Instr   <= src_adel ? 32'd0 : src_instr;
                D_ExcCode <= src_adel ? EXC_ADEL : 5'd0;
            end else begin
                // Memory-wait bubble keeps the delay-slot attribution for EPC/BD.
                D_PC      <= F_PC;
                D_Instr   <= 32'd0;
                D_ExcCode <= 5'd0;
                D_BD      <= D_isBranch;
                D_Valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios with literal expectations plus a
// randomized run checked against a queue-based reference model.
module tb_if_id_stage;

    localparam logic [31:0] PC_START   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] F_PC;
    logic [31:0] F_Instr;
    logic        F_ExcAdEL;
    logic        i_ready;
    logic        D_isBranch;
    logic        En;
    logic        req;
    logic        flush;
    logic        if_stall;
    logic [31:0] D_PC;
    logic [31:0] D_Instr;
    logic [4:0]  D_ExcCode;
    logic        D_BD;
    logic        D_Valid;
    logic        dbg_held;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the hold buffer is a queue of at most one {pc, instr, adel, bd}.
    logic [65:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [4:0]  exp_exc;
    logic        exp_bd;
    logic        exp_valid;

    if_id_stage dut (
        .clk(clk), .reset(reset), .F_PC(F_PC), .F_Instr(F_Instr),
        .F_ExcAdEL(F_ExcAdEL), .i_ready(i_ready), .D_isBranch(D_isBranch),
        .En(En), .req(req), .flush(flush), .if_stall(if_stall),
        .D_PC(D_PC), .D_Instr(D_Instr), .D_ExcCode(D_ExcCode), .D_BD(D_BD),
        .D_Valid(D_Valid), .dbg_held(dbg_held)
    );

    always #5 clk = ~clk;

    task automatic set_d(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [4:0] exc, input logic bd, input logic valid);
        exp_pc = pc; exp_instr = instr; exp_exc = exc; exp_bd = bd; exp_valid = valid;
    endtask

    // Applies the current inputs to the model, then advances one clock edge.
    task automatic step();
        logic [65:0] e;
        if (reset) begin
            set_d(PC_START, 32'd0, 5'd0, 1'b0, 1'b0);
            exp_q.delete();
        end else if (req) begin
            set_d(HANDLER_PC, 32'd0, 5'd0, 1'b0, 1'b0);
            exp_q.delete();
        end else if (flush) begin
            set_d(F_PC, 32'd0, 5'd0, 1'b0, 1'b0);
            exp_q.delete();
        end else if (!En) begin
            if (exp_q.size() == 0 && (i_ready || F_ExcAdEL))
                exp_q.push_back({F_PC, F_Instr, F_ExcAdEL, D_isBranch});
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            set_d(e[65:34], e[1] ? 32'd0 : e[33:2], e[1] ? EXC_ADEL : 5'd0, e[0], 1'b1);
        end else if (i_ready || F_ExcAdEL) begin
            set_d(F_PC, F_ExcAdEL ? 32'd0 : F_Instr, F_ExcAdEL ? EXC_ADEL : 5'd0,
                  D_isBranch, 1'b1);
        end else begin
            set_d(F_PC, 32'd0, 5'd0, D_isBranch, 1'b0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; F_PC = PC_START; F_Instr = 32'd0; F_ExcAdEL = 1'b0;
        i_ready = 1'b1; D_isBranch = 1'b0; En = 1'b1; req = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        n_vec++;
        if (D_PC !== PC_START || D_Valid !== 1'b0 || D_Instr !== 32'd0 ||
            D_ExcCode !== 5'd0 || D_BD !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: pc=%h v=%b instr=%h exc=%0d bd=%b, want pc=%h v=0 instr=0 exc=0 bd=0",
                     D_PC, D_Valid, D_Instr, D_ExcCode, D_BD, PC_START);
        end
        reset = 1'b0; F_PC = 32'h3000; F_Instr = 32'h3c010001;
        #1;
        n_vec++;
        if (if_stall !== 1'b0) begin
            n_err++; $display("FAIL reset_stall: if_stall=%b want 0", if_stall);
        end
        step();
        n_vec++;
        if (D_Instr !== 32'h3c010001 || D_Valid !== 1'b1 || D_PC !== 32'h3000) begin
            n_err++;
            $display("FAIL first_fetch: instr=%h v=%b pc=%h want 3c010001 1 00003000", D_Instr, D_Valid, D_PC);
        end
    endtask

    task automatic test_wait_states();
        i_ready = 1'b0; F_PC = 32'h3004; F_Instr = 32'hdeadbeef;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (if_stall !== 1'b1) begin
                n_err++; $display("FAIL wait_stall[%0d]: if_stall=%b want 1", i, if_stall);
            end
            step();
            n_vec++;
            if (D_Valid !== 1'b0 || D_PC !== 32'h3004 || D_Instr !== 32'd0) begin
                n_err++;
                $display("FAIL wait_bubble[%0d]: v=%b pc=%h instr=%h want 0 00003004 0", i, D_Valid, D_PC, D_Instr);
            end
        end
        i_ready = 1'b1; F_Instr = 32'h0000_0000;
        #1;
        n_vec++;
        if (if_stall !== 1'b0) begin
            n_err++; $display("FAIL wait_release: if_stall=%b want 0", if_stall);
        end
        step();
        n_vec++;
        if (D_PC !== 32'h3004 || D_Valid !== 1'b1) begin
            n_err++; $display("FAIL wait_capture: pc=%h v=%b want 00003004 1", D_PC, D_Valid);
        end
    endtask

    task automatic test_stall_capture();
        logic [31:0] pc_before;
        logic [31:0] instr_before;
        pc_before = D_PC; instr_before = D_Instr;
        En = 1'b0; i_ready = 1'b1; F_PC = 32'h3008; F_Instr = 32'h8c220000;
        step();
        n_vec++;
        if (D_PC !== pc_before || D_Instr !== instr_before || dbg_held !== 1'b1) begin
            n_err++;
            $display("FAIL capture_hold: pc=%h instr=%h held=%b want %h %h 1",
                     D_PC, D_Instr, dbg_held, pc_before, instr_before);
        end
        En = 1'b1; i_ready = 1'b0; F_PC = 32'h300c; F_Instr = 32'h11111111;
        #1;
        n_vec++;
        if (if_stall !== 1'b0) begin
            n_err++; $display("FAIL held_stall: if_stall=%b want 0", if_stall);
        end
        step();
        n_vec++;
        if (D_Instr !== 32'h8c220000 || D_PC !== 32'h3008 || D_Valid !== 1'b1 || dbg_held !== 1'b0) begin
            n_err++;
            $display("FAIL capture_release: instr=%h pc=%h v=%b held=%b want 8c220000 00003008 1 0",
                     D_Instr, D_PC, D_Valid, dbg_held);
        end
    endtask

    task automatic test_adel();
        F_PC = 32'h3002; F_ExcAdEL = 1'b1; i_ready = 1'b0; F_Instr = 32'h12345678;
        #1;
        n_vec++;
        if (if_stall !== 1'b0) begin
            n_err++; $display("FAIL adel_stall: if_stall=%b want 0", if_stall);
        end
        step();
        n_vec++;
        if (D_Instr !== 32'd0 || D_ExcCode !== EXC_ADEL || D_Valid !== 1'b1 || D_PC !== 32'h3002) begin
            n_err++;
            $display("FAIL adel_capture: instr=%h exc=%0d v=%b pc=%h want 0 4 1 00003002",
                     D_Instr, D_ExcCode, D_Valid, D_PC);
        end
        F_ExcAdEL = 1'b0;
    endtask

    task automatic test_delay_slot();
        i_ready = 1'b1; En = 1'b1; F_PC = 32'h3010; F_Instr = 32'h00000001; D_isBranch = 1'b1;
        step();
        n_vec++;
        if (D_BD !== 1'b1 || D_PC !== 32'h3010) begin
            n_err++; $display("FAIL bd_direct: bd=%b pc=%h want 1 00003010", D_BD, D_PC);
        end
        En = 1'b0; F_PC = 32'h3014; F_Instr = 32'h00000002; D_isBranch = 1'b1;
        step();
        En = 1'b1; i_ready = 1'b0; D_isBranch = 1'b0; F_PC = 32'h3018;
        step();
        n_vec++;
        if (D_BD !== 1'b1 || D_PC !== 32'h3014 || D_Instr !== 32'h00000002) begin
            n_err++;
            $display("FAIL bd_deferred: bd=%b pc=%h instr=%h want 1 00003014 00000002", D_BD, D_PC, D_Instr);
        end
        step();
        n_vec++;
        if (D_BD !== 1'b0 || D_Valid !== 1'b0 || D_PC !== 32'h3018) begin
            n_err++; $display("FAIL bd_wait_bubble: bd=%b v=%b pc=%h want 0 0 00003018", D_BD, D_Valid, D_PC);
        end
    endtask

    task automatic test_exc_held();
        En = 1'b0; i_ready = 1'b1; F_PC = 32'h3020; F_Instr = 32'haaaa5555;
        step();
        req = 1'b1;
        step();
        n_vec++;
        if (D_PC !== HANDLER_PC || D_Valid !== 1'b0 || dbg_held !== 1'b0 || D_ExcCode !== 5'd0) begin
            n_err++;
            $display("FAIL req_held: pc=%h v=%b held=%b exc=%0d want 00004180 0 0 0",
                     D_PC, D_Valid, dbg_held, D_ExcCode);
        end
        req = 1'b0; flush = 1'b1; F_PC = HANDLER_PC; En = 1'b1;
        step();
        n_vec++;
        if (D_PC !== HANDLER_PC || D_Valid !== 1'b0 || D_Instr !== 32'd0 || D_BD !== 1'b0) begin
            n_err++;
            $display("FAIL flush_bubble: pc=%h v=%b instr=%h bd=%b want 00004180 0 0 0", D_PC, D_Valid, D_Instr, D_BD);
        end
        flush = 1'b0;
    endtask

    task automatic test_random();
        logic exp_stall;
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 63) == 0);
            req        = ($urandom_range(0, 15) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            En         = ($urandom_range(0, 3) != 0);
            i_ready    = ($urandom_range(0, 9) < 6);
            F_ExcAdEL  = ($urandom_range(0, 9) == 0);
            D_isBranch = ($urandom_range(0, 3) == 0);
            F_PC       = 32'h3000 + ($urandom_range(0, 255) << 2);
            F_Instr    = $urandom;
            #1;
            exp_stall = (exp_q.size() == 0) && !i_ready && !F_ExcAdEL;
            n_vec++;
            if (if_stall !== exp_stall) begin
                n_err++; $display("FAIL rand_stall[%0d]: if_stall=%b want %b", i, if_stall, exp_stall);
            end
            step();
            n_vec++;
            if (D_PC !== exp_pc || D_Instr !== exp_instr || D_ExcCode !== exp_exc ||
                D_BD !== exp_bd || D_Valid !== exp_valid || dbg_held !== (exp_q.size() != 0)) begin
                n_err++;
                $display("FAIL rand_d[%0d]: got pc=%h instr=%h exc=%0d bd=%b v=%b held=%b want pc=%h instr=%h exc=%0d bd=%b v=%b held=%b",
                         i, D_PC, D_Instr, D_ExcCode, D_BD, D_Valid, dbg_held,
                         exp_pc, exp_instr, exp_exc, exp_bd, exp_valid, exp_q.size() != 0);
            end
        end
    endtask

    initial begin
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_wait_states();
        test_stall_capture();
        test_adel();
        test_delay_slot();
        test_exc_held();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
